// File: rtl/qsys_device_arbiter.sv
// qsys_device_arbiter: round-robin sharing of one 16-bit Qsys device between two Avalon-MM slave ports
module qsys_device_arbiter #(
  parameter int          address_size = 5,
  parameter int          TIMEOUT      = 256,
  parameter logic [15:0] ERR_DATA     = 16'hDEAD
) (
  input  logic                  csi_MCLK_clk,
  input  logic                  rsi_MRST_reset_n,
  input  logic [address_size:0] s0_address,
  input  logic [15:0]           s0_writedata,
  input  logic [1:0]            s0_byteenable,
  input  logic                  s0_write,
  input  logic                  s0_read,
  output logic [15:0]           s0_readdata,
  output logic                  s0_waitrequest,
  input  logic [address_size:0] s1_address,
  input  logic [15:0]           s1_writedata,
  input  logic [1:0]            s1_byteenable,
  input  logic                  s1_write,
  input  logic                  s1_read,
  output logic [15:0]           s1_readdata,
  output logic                  s1_waitrequest,
  output logic [address_size:0] device_address,
  output logic [15:0]           device_writedata,
  output logic [1:0]            device_byteenable,
  output logic                  device_write,
  output logic                  device_read,
  input  logic [15:0]           device_readdata,
  input  logic                  device_waitrequest,
  input  logic                  timeout_clear,
  output logic                  timeout_err,
  output logic                  owner
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic rr_ptr, s0_req, s1_req, winner, grant, done_ok, tmo, w_write, w_read;
  logic [CW-1:0] counter;
  logic [15:0] rd_val;
  assign s0_req = s0_read | s0_write;
  assign s1_req = s1_read | s1_write;
  assign winner = (s0_req && s1_req) ? rr_ptr : s1_req;
  assign grant = (state == IDLE) && (s0_req || s1_req);
  assign done_ok = (state == BUSY) && !device_waitrequest;
  assign tmo = (state == BUSY) && device_waitrequest && (counter == CW'(TIMEOUT - 1));
  assign w_write = winner ? s1_write : s0_write;
  assign w_read = winner ? s1_read : s0_read;
  assign rd_val = done_ok ? device_readdata : ERR_DATA;
  assign s0_waitrequest = !((state == DONE) && !owner);
  assign s1_waitrequest = !((state == DONE) && owner);
  always_comb begin
    state_nxt = IDLE;
    state_nxt = (state == IDLE) ? (grant ? BUSY : IDLE) :
                (state == BUSY) ? ((done_ok || tmo) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n)
    if (!rsi_MRST_reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      rr_ptr <= 1'b0;
      owner <= 1'b0;
      counter <= '0;
      device_address <= '0;
      device_writedata <= '0;
      device_byteenable <= '0;
      device_write <= 1'b0;
      device_read <= 1'b0;
      s0_readdata <= '0;
      s1_readdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant) begin
        owner <= winner;
        device_address <= winner ? s1_address : s0_address;
        device_writedata <= winner ? s1_writedata : s0_writedata;
        device_byteenable <= winner ? s1_byteenable : s0_byteenable;
        device_write <= w_write;
        device_read <= w_read & ~w_write;
        counter <= '0;
      end
      if (state == BUSY) begin
        if (done_ok || tmo) begin
          device_read <= 1'b0;
          device_write <= 1'b0;
        end else counter <= counter + CW'(1);
        if ((done_ok || tmo) && device_read) begin
          if (owner) s1_readdata <= rd_val;
          else s0_readdata <= rd_val;
        end
      end
      if (state == DONE) rr_ptr <= ~owner;
      timeout_err <= tmo | (timeout_err & ~timeout_clear);
    end
  end
endmodule

// File: tb/tb_qsys_device_arbiter.sv
// tb_qsys_device_arbiter: directed vector table plus hand sequences for wait states, timeout and reset
module tb_qsys_device_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] s0_address, s1_address, device_address;
  logic [15:0] s0_writedata, s1_writedata, s0_readdata, s1_readdata, device_writedata, device_readdata;
  logic [1:0] s0_byteenable, s1_byteenable, device_byteenable;
  logic s0_write, s0_read, s1_write, s1_read, s0_waitrequest, s1_waitrequest;
  logic device_write, device_read, device_waitrequest, timeout_clear, timeout_err, owner;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [3:0]  req;
    logic        dr, dw;
    logic [5:0]  addr;
    logic [15:0] wd;
    logic [1:0]  be, wt;
    logic        own;
    logic [15:0] rd0;
  } vec_t;
  vec_t vecs[$];

  qsys_device_arbiter #(.address_size(5), .TIMEOUT(8), .ERR_DATA(16'hDEAD)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
    .s0_address(s0_address), .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_write(s0_write), .s0_read(s0_read), .s0_readdata(s0_readdata), .s0_waitrequest(s0_waitrequest),
    .s1_address(s1_address), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_write(s1_write), .s1_read(s1_read), .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest),
    .device_address(device_address), .device_writedata(device_writedata),
    .device_byteenable(device_byteenable), .device_write(device_write), .device_read(device_read),
    .device_readdata(device_readdata), .device_waitrequest(device_waitrequest),
    .timeout_clear(timeout_clear), .timeout_err(timeout_err), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic dr, input logic dw, input logic [5:0] addr,
                     input logic [15:0] wd, input logic [1:0] be, input logic [1:0] wt,
                     input logic own, input logic [15:0] rd0);
    vec_t v;
    v.req = req; v.dr = dr; v.dw = dw; v.addr = addr; v.wd = wd;
    v.be = be; v.wt = wt; v.own = own; v.rd0 = rd0;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {s0_read, s0_write, s1_read, s1_write} = 4'b0;
    device_waitrequest = 1'b0;
    timeout_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    s0_address = 6'd3; s0_writedata = 16'hA000; s0_byteenable = 2'b11;
    s1_address = 6'd7; s1_writedata = 16'hB111; s1_byteenable = 2'b10;
    device_readdata = 16'h1234;
    // req = {s0_read, s0_write, s1_read, s1_write}; wt = {s1_waitrequest, s0_waitrequest}
    add(4'b0101, 0, 0, 0, 16'h0000, 2'b00, 2'b11, 0, 16'h0000);
    add(4'b0101, 0, 1, 3, 16'hA000, 2'b11, 2'b11, 0, 16'h0000);
    add(4'b0101, 0, 0, 3, 16'hA000, 2'b11, 2'b10, 0, 16'h0000);
    add(4'b0101, 0, 0, 3, 16'hA000, 2'b11, 2'b11, 0, 16'h0000);
    add(4'b0101, 0, 1, 7, 16'hB111, 2'b10, 2'b11, 1, 16'h0000);
    add(4'b0101, 0, 0, 7, 16'hB111, 2'b10, 2'b01, 1, 16'h0000);
    add(4'b0101, 0, 0, 7, 16'hB111, 2'b10, 2'b11, 1, 16'h0000);
    add(4'b0101, 0, 1, 3, 16'hA000, 2'b11, 2'b11, 0, 16'h0000);
    add(4'b0101, 0, 0, 3, 16'hA000, 2'b11, 2'b10, 0, 16'h0000);
    add(4'b0101, 0, 0, 3, 16'hA000, 2'b11, 2'b11, 0, 16'h0000);
    add(4'b0101, 0, 1, 7, 16'hB111, 2'b10, 2'b11, 1, 16'h0000);
    add(4'b0101, 0, 0, 7, 16'hB111, 2'b10, 2'b01, 1, 16'h0000);
    add(4'b1000, 0, 0, 7, 16'hB111, 2'b10, 2'b11, 1, 16'h0000);
    add(4'b1000, 1, 0, 3, 16'hA000, 2'b11, 2'b11, 0, 16'h0000);
    add(4'b1000, 0, 0, 3, 16'hA000, 2'b11, 2'b10, 0, 16'h1234);
    add(4'b0011, 0, 0, 3, 16'hA000, 2'b11, 2'b11, 0, 16'h1234);
    add(4'b0011, 0, 1, 7, 16'hB111, 2'b10, 2'b11, 1, 16'h1234);
    add(4'b0011, 0, 0, 7, 16'hB111, 2'b10, 2'b01, 1, 16'h1234);
    add(4'b0000, 0, 0, 7, 16'hB111, 2'b10, 2'b11, 1, 16'h1234);

    do_reset();
    #1;
    chk("reset timeout_err", timeout_err, 0);
    chk("reset s1_readdata", s1_readdata, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {s0_read, s0_write, s1_read, s1_write} = vecs[i].req;
      #1;
      chk($sformatf("v%0d device_read", i), device_read, vecs[i].dr);
      chk($sformatf("v%0d device_write", i), device_write, vecs[i].dw);
      chk($sformatf("v%0d device_address", i), device_address, vecs[i].addr);
      chk($sformatf("v%0d device_writedata", i), device_writedata, vecs[i].wd);
      chk($sformatf("v%0d device_byteenable", i), device_byteenable, vecs[i].be);
      chk($sformatf("v%0d waitrequest", i), {s1_waitrequest, s0_waitrequest}, vecs[i].wt);
      chk($sformatf("v%0d owner", i), owner, vecs[i].own);
      chk($sformatf("v%0d s0_readdata", i), s0_readdata, vecs[i].rd0);
    end
    chk("rw s1_readdata untouched", s1_readdata, 0);

    // wait states: five stalled cycles on an s1 write, then completion
    do_reset();
    s1_writedata = 16'hBEEF; s1_byteenable = 2'b10; s1_write = 1'b1;
    device_waitrequest = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      device_waitrequest = (k < 5);
      #1;
      chk($sformatf("ws%0d device_write", k), device_write, 1);
      chk($sformatf("ws%0d device_writedata", k), device_writedata, 16'hBEEF);
      chk($sformatf("ws%0d device_be", k), device_byteenable, 2'b10);
      chk($sformatf("ws%0d waitrequest", k), {s1_waitrequest, s0_waitrequest}, 2'b11);
    end
    @(negedge clk); #1;
    chk("ws done waitrequest", {s1_waitrequest, s0_waitrequest}, 2'b01);
    chk("ws done device_write", device_write, 0);
    s1_write = 1'b0;
    @(negedge clk); #1;
    chk("ws idle waitrequest", {s1_waitrequest, s0_waitrequest}, 2'b11);
    chk("ws idle timeout_err", timeout_err, 0);

    // timeout: device never responds to an s0 read
    s0_read = 1'b1;
    device_waitrequest = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk($sformatf("to%0d device_read", k), device_read, 1);
      chk($sformatf("to%0d s0_waitrequest", k), s0_waitrequest, 1);
    end
    @(negedge clk); #1;
    chk("to done device_read", device_read, 0);
    chk("to done s0_waitrequest", s0_waitrequest, 0);
    chk("to s0_readdata", s0_readdata, 16'hDEAD);
    chk("to timeout_err", timeout_err, 1);
    s0_read = 1'b0;
    @(negedge clk); #1;
    chk("to sticky", timeout_err, 1);
    timeout_clear = 1'b1;
    @(negedge clk);
    timeout_clear = 1'b0;
    #1;
    chk("to cleared", timeout_err, 0);

    // reset during the third wait cycle, then contention after release
    s0_read = 1'b1;
    device_waitrequest = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst pre device_read", device_read, 1);
    rst_n = 1'b0;
    #1;
    chk("rst async device_read", device_read, 0);
    chk("rst waitrequest", {s1_waitrequest, s0_waitrequest}, 2'b11);
    chk("rst s0_readdata", s0_readdata, 0);
    s1_read = 1'b1;
    device_waitrequest = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst regrant owner", owner, 0);
    chk("rst regrant device_read", device_read, 1);
    chk("rst regrant address", device_address, 3);
    {s0_read, s1_read} = 2'b00;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
